// File: rtl/preproc.sv
// preproc -- front end of the FFT/IFFT core.
//   FFT mode  (fft_type=0): drops the cyclic prefix of each input symbol, stores
//     the N useful samples in one half of a ping-pong RAM, then replays them to
//     the core as a gap-free sop/eop framed burst (one sample per clock).
//   IFFT mode (fft_type=1): one-cycle registered pass-through.
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   fft_type, cp_type       mode select, normal/extended CP
//   fft_num                 size code, N = 2048 >> fft_num
//   din_h/din_s/din_v       symbol head, slot-first flag, sample valid
//   din_i/din_q             input sample
//   dout_sop/eop/valid/fst  output framing
//   dout_real/dout_imag     output sample (zero when not valid)
module preproc #(
  parameter int DATA_NBIT = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 fft_type,
  input  logic                 cp_type,
  input  logic [2:0]           fft_num,
  input  logic                 din_h,
  input  logic                 din_s,
  input  logic                 din_v,
  input  logic [DATA_NBIT-1:0] din_i,
  input  logic [DATA_NBIT-1:0] din_q,
  output logic                 dout_sop,
  output logic                 dout_eop,
  output logic                 dout_valid,
  output logic [DATA_NBIT-1:0] dout_real,
  output logic [DATA_NBIT-1:0] dout_imag,
  output logic                 dout_fst
);

  localparam int DW = 2 * DATA_NBIT;

  typedef enum logic [1:0] {W_IDLE, W_SKIP, W_FILL} w_state_t;
  typedef enum logic       {R_IDLE, R_BURST}        r_state_t;

  w_state_t    w_state;
  r_state_t    r_state;
  logic [11:0] count, n_lat, cp_lat, rd_n;
  logic [10:0] waddr, raddr;
  logic        bank, bank_d, fst_lat, rd_fst;
  logic        rd_vld, sop_q, eop_q;
  logic [DW-1:0] rdata;
  logic [DW-1:0] mem [0:4095];

  logic [11:0] n_in, cp_in;
  logic        sym_start, wr_en, wr_last, rd_en, rd_last, tog;

  always_comb begin
    n_in  = 12'd2048 >> fft_num;
    if (cp_type)    cp_in = 12'd512 >> fft_num;
    else if (din_s) cp_in = 12'd160 >> fft_num;
    else            cp_in = 12'd144 >> fft_num;
  end

  assign sym_start = din_h & din_v & ~fft_type;
  assign wr_en     = (w_state == W_FILL) & din_v & ~fft_type;
  assign wr_last   = wr_en & ({1'b0, waddr} == n_lat - 12'd1);
  assign rd_en     = (r_state == R_BURST);
  assign rd_last   = ({1'b0, raddr} == rd_n - 12'd1);
  // bank flips exactly once per completed symbol; the flip starts a burst
  assign tog       = bank ^ bank_d;

  // Write side. Later assignments win: a symbol head overrides the skip/fill
  // progress, but the write/toggle of a final sample still completes.
  always_ff @(posedge clk) begin
    if (reset) begin
      w_state <= W_IDLE;
      count   <= '0;
      waddr   <= '0;
      bank    <= 1'b0;
      n_lat   <= '0;
      cp_lat  <= '0;
      fst_lat <= 1'b0;
      rd_n    <= '0;
      rd_fst  <= 1'b0;
    end else if (fft_type) begin
      w_state <= W_IDLE;
    end else begin
      if (wr_en) begin
        if (wr_last) begin
          bank    <= ~bank;
          rd_n    <= n_lat;
          rd_fst  <= fst_lat;
          w_state <= W_IDLE;
        end else begin
          waddr <= waddr + 11'd1;
        end
      end
      if (w_state == W_SKIP && din_v) begin
        count <= count + 12'd1;
        if (count == cp_lat - 12'd1) begin
          w_state <= W_FILL;
          waddr   <= '0;
        end
      end
      if (sym_start) begin
        w_state <= W_SKIP;
        count   <= 12'd1;
        n_lat   <= n_in;
        cp_lat  <= cp_in;
        fst_lat <= din_s;
      end
    end
  end

  // Ping-pong RAM: writer fills 'bank', reader drains the other half.
  always_ff @(posedge clk) begin
    if (wr_en) mem[{bank, waddr}] <= {din_i, din_q};
    if (rd_en) rdata <= mem[{~bank, raddr}];
  end

  // Read side and output stage: raddr -> RAM read -> output register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= R_IDLE;
      raddr      <= '0;
      bank_d     <= 1'b0;
      rd_vld     <= 1'b0;
      sop_q      <= 1'b0;
      eop_q      <= 1'b0;
      dout_sop   <= 1'b0;
      dout_eop   <= 1'b0;
      dout_valid <= 1'b0;
      dout_fst   <= 1'b0;
      dout_real  <= '0;
      dout_imag  <= '0;
    end else begin
      bank_d <= bank;
      if (fft_type) begin
        r_state <= R_IDLE;
      end else if (tog) begin
        r_state <= R_BURST;
        raddr   <= '0;
      end else if (r_state == R_BURST) begin
        raddr <= raddr + 11'd1;
        if (rd_last) r_state <= R_IDLE;
      end
      rd_vld <= rd_en & ~fft_type;
      sop_q  <= rd_en & ~fft_type & (raddr == '0);
      eop_q  <= rd_en & ~fft_type & rd_last;
      if (fft_type) begin
        dout_valid <= din_v;
        dout_sop   <= din_h & din_v;
        dout_eop   <= 1'b0;
        dout_fst   <= din_h & din_v & din_s;
        dout_real  <= din_v ? din_i : '0;
        dout_imag  <= din_v ? din_q : '0;
      end else begin
        dout_valid <= rd_vld;
        dout_sop   <= sop_q;
        dout_eop   <= eop_q;
        dout_fst   <= sop_q & rd_fst;
        dout_real  <= rd_vld ? rdata[DW-1:DATA_NBIT] : '0;
        dout_imag  <= rd_vld ? rdata[DATA_NBIT-1:0] : '0;
      end
    end
  end

endmodule

// File: tb/tb_preproc.sv
module tb_preproc;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        fft_type = 1'b0, cp_type = 1'b0;
  logic [2:0]  fft_num = 3'd0;
  logic        din_h = 1'b0, din_s = 1'b0, din_v = 1'b0;
  logic [15:0] din_i = '0, din_q = '0;
  logic        dout_sop, dout_eop, dout_valid, dout_fst;
  logic [15:0] dout_real, dout_imag;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_e0 = 0;

  typedef struct {
    logic sop, eop, fst;
    logic [15:0] re, im;
    int c;
  } obs_t;
  obs_t q[$];

  preproc #(.DATA_NBIT(16)) dut (
    .clk(clk), .reset(reset), .fft_type(fft_type), .cp_type(cp_type),
    .fft_num(fft_num), .din_h(din_h), .din_s(din_s), .din_v(din_v),
    .din_i(din_i), .din_q(din_q), .dout_sop(dout_sop), .dout_eop(dout_eop),
    .dout_valid(dout_valid), .dout_real(dout_real), .dout_imag(dout_imag),
    .dout_fst(dout_fst)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    obs_t o;
    if (dout_valid) begin
      o.sop = dout_sop; o.eop = dout_eop; o.fst = dout_fst;
      o.re = dout_real; o.im = dout_imag; o.c = cyc;
      q.push_back(o);
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Sample index i carries I = i, Q = ~i.
  task automatic drive_sym(input int total, input int gap, input bit s);
    for (int i = 0; i < total; i++) begin
      din_h = (i == 0); din_s = s; din_v = 1'b1;
      din_i = 16'(i); din_q = ~16'(i);
      @(posedge clk); #1;
      last_e0 = cyc;
      din_v = 1'b0; din_h = 1'b0;
      step(gap);
    end
  endtask

  task automatic check_burst(input string tag, input int n, input int cp, input bit fst, input int e0);
    int t = 0;
    int nbad = 0;
    while (q.size() < n && t < 8000) begin step(1); t++; end
    check({tag, "_complete"}, 64'(q.size() >= n), 64'd1);
    if (q.size() < n) begin q.delete(); return; end
    for (int k = 0; k < n; k++) begin
      if (q[k].re !== 16'(cp + k) || q[k].im !== ~16'(cp + k) ||
          q[k].sop !== (k == 0) || q[k].eop !== (k == n - 1) ||
          q[k].fst !== (fst && k == 0) || q[k].c !== q[0].c + k)
        nbad++;
    end
    check({tag, "_bad_samples"}, 64'(nbad), 64'd0);
    check({tag, "_sop_latency"}, 64'(q[0].c), 64'(e0 + 3));
    check({tag, "_first_val"}, 64'(q[0].re), 64'(cp));
    check({tag, "_eop_val"}, {47'd0, q[n-1].eop, q[n-1].re}, {47'd0, 1'b1, 16'(cp + n - 1)});
    check({tag, "_fst"}, 64'(q[0].fst), 64'(fst));
    for (int k = 0; k < n; k++) void'(q.pop_front());
  endtask

  initial begin
    int e0a, e0b;
    logic v, h, s;
    logic [15:0] di, dq;
    int t;

    // reset state
    step(3);
    check("reset_outputs", {dout_sop, dout_eop, dout_valid, dout_fst, dout_real, dout_imag}, 64'd0);
    reset = 1'b0;
    step(2);

    // 2048, normal CP, slot-first: CP 160, din_v every other cycle
    fft_num = 3'd0; cp_type = 1'b0;
    drive_sym(2208, 1, 1'b1);
    check_burst("t1", 2048, 160, 1'b1, last_e0);
    step(20);
    check("t1_no_extra", 64'(q.size()), 64'd0);

    // 128, extended CP 32, din_v every cycle
    fft_num = 3'd4; cp_type = 1'b1;
    drive_sym(160, 0, 1'b0);
    check_burst("t2", 128, 32, 1'b0, last_e0);
    step(20);
    check("t2_no_extra", 64'(q.size()), 64'd0);

    // 512, normal CP 36, two back-to-back symbols
    fft_num = 3'd2; cp_type = 1'b0;
    drive_sym(548, 0, 1'b0);
    e0a = last_e0;
    drive_sym(548, 0, 1'b0);
    e0b = last_e0;
    check_burst("t3a", 512, 36, 1'b0, e0a);
    check_burst("t3b", 512, 36, 1'b0, e0b);
    step(20);
    check("t3_no_extra", 64'(q.size()), 64'd0);

    // truncated 2048 symbol then a full one (normal CP 144)
    fft_num = 3'd0;
    drive_sym(300, 0, 1'b0);
    drive_sym(2192, 0, 1'b0);
    check_burst("t4", 2048, 144, 1'b0, last_e0);
    step(20);
    check("t4_no_extra", 64'(q.size()), 64'd0);

    // IFFT pass-through, 1-cycle latency
    fft_type = 1'b1;
    step(2);
    for (int i = 0; i < 40; i++) begin
      v = 1'($urandom_range(0, 1)); h = (i % 7 == 0); s = 1'($urandom_range(0, 1));
      di = 16'($urandom); dq = 16'($urandom);
      din_v = v; din_h = h; din_s = s; din_i = di; din_q = dq;
      step(1);
      check("ifft_pass", {dout_valid, dout_sop, dout_eop, dout_fst, dout_real, dout_imag},
            {28'd0, v, h & v, 1'b0, h & v & s, v ? di : 16'd0, v ? dq : 16'd0});
    end
    din_v = 1'b0; din_h = 1'b0; din_s = 1'b0;
    step(2);
    fft_type = 1'b0;
    step(2);
    q.delete();

    // reset in the middle of a burst
    fft_num = 3'd4; cp_type = 1'b1;
    drive_sym(160, 0, 1'b0);
    t = 0;
    while (q.size() < 20 && t < 1000) begin step(1); t++; end
    check("t6_burst_started", 64'(q.size() >= 20), 64'd1);
    reset = 1'b1;
    step(1);
    check("t6_reset_outputs", {dout_sop, dout_eop, dout_valid, dout_fst, dout_real, dout_imag}, 64'd0);
    step(1);
    reset = 1'b0;
    q.delete();
    step(200);
    check("t6_burst_dropped", 64'(q.size()), 64'd0);
    cp_type = 1'b0;
    drive_sym(138, 0, 1'b1);
    check_burst("t6", 128, 10, 1'b1, last_e0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/preproc.md
# preproc

Pre-processing ahead of the FFT/IFFT core, mirroring the IFFT-side CP inserter at the core output.
- FFT mode: strips the cyclic prefix from each incoming time-domain OFDM symbol and buffers the useful part in a ping-pong RAM. It replays that part to the core as one contiguous sop/eop-framed burst at clock rate.
- IFFT mode: registered pass-through.

## Interface
- DATA_NBIT, 16, sample width of each of I and Q
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- fft_type  input  1  0 = FFT (remove CP), 1 = IFFT (pass through); changed only while no symbol is in flight
- cp_type  input  1  0 = normal CP, 1 = extended CP
- fft_num  input  3  size code: 0 = 2048, 1 = 1024, 2 = 512, 3 = 256, 4 = 128
- din_h  input  1  first sample of a symbol (first CP sample); qualified by din_v
- din_s  input  1  first symbol of a time slot; sampled with din_h
- din_v  input  1  sample valid; at most one per cycle, any spacing
- din_i, din_q  input  DATA_NBIT  I/Q sample
- dout_sop  output  1  first sample of a burst
- dout_eop  output  1  last sample of a burst
- dout_valid  output  1  sample valid
- dout_real, dout_imag  output  DATA_NBIT  I/Q to the core; 0 when dout_valid is low
- dout_fst  output  1  burst belongs to a slot-first symbol; valid with dout_sop

## Operation
- Sizes are taken from lte_fft_inc.v constants:
  - N = 2048 >> fft_num.
  - CP length = 512 >> fft_num (extended), 160 >> fft_num (normal, din_s = 1), or 144 >> fft_num (normal, din_s = 0).
  - Counters are 12 bits wide.
- All three sizes (N, CP length, fst) are latched on din_h & din_v. Later changes to the inputs do not affect a symbol in flight.
- Write FSM (FFT mode) has states W_IDLE, W_SKIP and W_FILL.
  - din_h & din_v in any state: the cycle's sample is CP sample 0, and the FSM goes to W_SKIP with count = 1.
  - W_SKIP: discards valid samples until count = CP length, then moves to W_FILL with address 0.
  - W_FILL: writes each valid sample {i, q} to address {bank, addr}, with addr incrementing.
  - W_FILL end: on the write of addr N-1, bank toggles, fst and N are latched for the reader, and the FSM returns to W_IDLE.
  - din_v without din_h in W_IDLE is ignored.
- Truncated symbol: a din_h during W_SKIP or W_FILL abandons the partial symbol and restarts. The bank does not toggle and no burst is produced.
- RAM: 2 × 2048 words of 2·DATA_NBIT bits, simple dual-port, registered read.
  - Read-during-write returns old data.
  - The reader always reads bank ~bank.
- Read FSM has states R_IDLE and R_BURST.
  - A bank toggle (detected edge) enters R_BURST with raddr = 0.
  - raddr increments every cycle until N-1, then the FSM returns to R_IDLE.
- Rate guarantee: a burst of N cycles is shorter than the input time of the next symbol (at least CP length + N cycles). Overlap is therefore impossible, and no backpressure exists.
- IFFT mode: din is registered once.
  - dout_valid = din_v.
  - dout_sop = din_h & din_v.
  - dout_eop = 0.
  - dout_fst = din_h & din_v & din_s.
  - Both FSMs are held in idle.

## Timing
- Reset values: dout_* = 0, FSMs idle, bank = 0, all counters 0. RAM contents are not reset.
- FFT latency: let E0 be the edge capturing the sample at addr N-1.
  - dout_sop and dout_valid are high after edge E0+3, carrying the sample at addr 0.
  - dout_valid then stays high for N consecutive cycles.
  - dout_eop is high on the N-th cycle, with addr N-1.
- Burst data is exactly the input samples with indices CP length … CP length+N-1, counted from din_h, in order.
- IFFT latency: 1 cycle.
- A din_h coinciding with the last write (E0) is treated as the next symbol's sample 0. The completed symbol is still toggled and read out.
- Reset mid-burst: outputs are 0 on the next cycle, and the remaining burst is dropped.

## Test plan
- FFT, fft_num=0, cp_type=0, din_s=1, din_v every 2nd cycle, sample value = index 0..2207 → one burst of 2048 values 160..2207. sop comes 3 cycles after index 2207 is captured, eop on value 2207, dout_fst=1.
- FFT, fft_num=4, cp_type=1, din_v every cycle, index 0..159 → 128 values 32..159, eop on 159.
- FFT, fft_num=2, normal CP, din_s=0, two back-to-back symbols → two bursts of 512 values 36..547 of each symbol. The banks alternate, and there are no gaps inside a burst.
- FFT, din_h reasserted after 300 samples of a 2048 symbol → no burst for the aborted symbol. The following full symbol yields the correct 144..2191.
- IFFT mode, random stream with din_h pulses → outputs equal inputs delayed 1 cycle, sop aligned to din_h.
- Reset asserted mid-burst → all outputs 0 the cycle after. The next symbol is processed correctly from bank 0.
